fir_mac_scheduler: RTL and testbench

//  Time-multiplexed 41-tap FIR engine: one shared signed multiply-accumulate unit is sequenced over all taps per sample.
//  It replaces the fully parallel 41-multiplier low-pass where throughput of 1 sample per NUM_TAPS+2 clocks suffices.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_mac_unit.sv | 25 ++
 rtl/fir_mac_scheduler.sv | 142 ++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and default low-pass coefficients for the
// time-multiplexed FIR engine.
package fir_pkg;
  localparam int NUM_TAPS = 41;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 12;
  localparam int ACC_W    = 41;
  localparam int KW       = $clog2(NUM_TAPS);
  localparam int PROD_W   = DATA_W + COEF_W;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_HOLD} state_t;

  // Symmetric table: only the first half plus centre is stored, the rest mirrors.
  function automatic logic signed [COEF_W-1:0] def_coef(input logic [KW-1:0] k);
    logic [KW-1:0] m;
    m = (k > KW'(NUM_TAPS / 2)) ? KW'(NUM_TAPS - 1) - k : k;
    case (int'(m))
      0:  return 12'sd19;
      1:  return 12'sd15;
      2:  return 12'sd9;
      3:  return -12'sd3;
      4:  return -12'sd24;
      5:  return -12'sd57;
      6:  return -12'sd99;
      7:  return -12'sd143;
      8:  return -12'sd177;
      9:  return -12'sd185;
      10: return -12'sd151;
      11: return -12'sd60;
      12: return 12'sd99;
      13: return 12'sd325;
      14: return 12'sd610;
      15: return 12'sd933;
      16: return 12'sd1266;
      17: return 12'sd1575;
      18: return 12'sd1826;
      19: return 12'sd1990;
      20: return 12'sd2047;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; o_sum is the value the accumulator
// takes on the next enabled edge, so the final tap can be captured directly.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_c,
  output logic signed [ACC_W-1:0]  o_sum
);
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = i_x * i_c;
  assign o_sum  = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_sum;
  end
endmodule

// File: rtl/fir_mac_scheduler.sv
// 41-tap FIR sequenced over one shared MAC: CLEAR -> IDLE -> RUN -> HOLD -> IDLE.
// Build option FIR_COEF_WR_EN adds a writable shadow coefficient bank with swap.
module fir_mac_scheduler
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     busy
`ifdef FIR_COEF_WR_EN
  ,
  input  logic                     coef_we,
  input  logic [6:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_swap
`endif
);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_TAPS - 1);

  state_t                   r_state, w_state_nxt;
  logic [KW-1:0]            r_k, r_wr_ptr, r_rd_idx;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_out_data;
  logic                     w_last, w_mac_clr, w_mac_en, w_buf_we;
  logic [KW-1:0]            w_buf_idx;
  logic signed [DATA_W-1:0] w_buf_wd, w_x;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] r_buf [NUM_TAPS];

  assign w_last    = (r_k == K_LAST);
  assign w_x       = r_buf[r_rd_idx];
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    w_state_nxt = r_state;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    w_buf_we    = 1'b0;
    w_buf_idx   = r_k;
    w_buf_wd    = '0;
    case (r_state)
      S_CLEAR: begin
        w_buf_we = 1'b1;
        if (w_last) w_state_nxt = S_IDLE;
      end
      S_IDLE: if (in_valid) begin
        w_state_nxt = S_RUN;
        w_mac_clr   = 1'b1;
        w_buf_we    = 1'b1;
        w_buf_idx   = r_wr_ptr;
        w_buf_wd    = in_data;
      end
      S_RUN: begin
        w_mac_en = 1'b1;
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_k         <= '0;
      r_wr_ptr    <= '0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_CLEAR: r_k <= w_last ? '0 : r_k + KW'(1);
        S_IDLE: if (in_valid) begin
          r_k      <= '0;
          r_rd_idx <= r_wr_ptr;
        end
        S_RUN: begin
          // Walk from the newest sample backwards through the circular buffer.
          r_k      <= r_k + KW'(1);
          r_rd_idx <= (r_rd_idx == '0) ? K_LAST : r_rd_idx - KW'(1);
          if (w_last) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            r_wr_ptr    <= (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + KW'(1);
          end
        end
        S_HOLD: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_idx] <= w_buf_wd;
  end

`ifdef FIR_COEF_WR_EN
  logic signed [COEF_W-1:0] r_bank [2][NUM_TAPS];
  logic                     r_active, r_swap_pend, w_swap_go;

  // Swap only between samples so a result never mixes two banks.
  assign w_swap_go = (r_state == S_IDLE) && r_swap_pend;
  assign w_coef    = r_bank[r_active][r_k];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= 1'b0;
      r_swap_pend <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < NUM_TAPS; t++)
          r_bank[b][t] <= def_coef(KW'(t));
    end else begin
      if (coef_we && (coef_addr < 7'(NUM_TAPS)))
        r_bank[~r_active][coef_addr[KW-1:0]] <= coef_wdata;
      if (w_swap_go) r_active <= ~r_active;
      r_swap_pend <= coef_swap | (r_swap_pend & ~w_swap_go);
    end
  end
`else
  assign w_coef = def_coef(r_k);
`endif

  fir_mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_x   (w_x),
    .i_c   (w_coef),
    .o_sum (w_sum)
  );
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: table-driven impulse response,
// randomized samples against a convolution model, stall, throughput and reset cases.
module tb_fir_mac_scheduler;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic signed [DATA_W-1:0] in_data = '0;
  logic signed [ACC_W-1:0]  out_data;
`ifdef FIR_COEF_WR_EN
  logic                     coef_we = 1'b0;
  logic                     coef_swap = 1'b0;
  logic [6:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
`endif

  int checks = 0;
  int errors = 0;
  int COEF_H [21] = '{19, 15, 9, -3, -24, -57, -99, -143, -177, -185, -151,
                      -60, 99, 325, 610, 933, 1266, 1575, 1826, 1990, 2047};
  bit use_unit = 1'b0;
  logic signed [DATA_W-1:0] hist [$];

  typedef struct {
    logic signed [DATA_W-1:0] din;
    longint                   exp;
  } vec_t;
  vec_t tbl [42];

  always #5 clk = ~clk;

  fir_mac_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
`ifdef FIR_COEF_WR_EN
    ,
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_swap  (coef_swap)
`endif
  );

  function automatic longint ref_coef(input int k);
    if (use_unit) return (k == 0) ? 64'sd1 : 64'sd0;
    return longint'(COEF_H[(k <= 20) ? k : 40 - k]);
  endfunction

  // Direct convolution over the last NUM_TAPS accepted samples (missing ones are zero).
  function automatic longint model_push(input logic signed [DATA_W-1:0] d);
    longint s;
    s = 0;
    hist.push_front(d);
    if (hist.size() > NUM_TAPS) void'(hist.pop_back());
    for (int k = 0; k < hist.size(); k++) s += ref_coef(k) * longint'(hist[k]);
    s = (s <<< 23) >>> 23;
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_sample(input logic signed [DATA_W-1:0] d, input int stall,
                           input logic signed [DATA_W-1:0] nxt, input string nm,
                           input longint tbl_exp, input bit use_tbl);
    longint e;
    int n;
    logic signed [ACC_W-1:0] held;
    e = model_push(d);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin tick; n++; end
    chk({nm, "_rdy"}, longint'(in_ready), 1);
    out_ready = (stall == 0);
    tick;
    in_valid = (stall > 0);
    in_data  = nxt;
    n = 0;
    while (!out_valid && n < 60) begin tick; n++; end
    chk({nm, "_lat"}, n, 41);
    chk({nm, "_data"}, out_data, use_tbl ? tbl_exp : e);
    chk({nm, "_busy"}, longint'(busy), 1);
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({nm, "_stall_v"}, longint'(out_valid), 1);
      chk({nm, "_stall_d"}, out_data, held);
      chk({nm, "_stall_r"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick;
    chk({nm, "_done_v"}, longint'(out_valid), 0);
    chk({nm, "_done_r"}, longint'(in_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    longint expq [$];
    logic signed [DATA_W-1:0] rd [21];

    // Reset state and CLEAR length
    #2 rst_n = 1'b0;
    tick; tick;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", longint'(busy), 1);
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      chk("clear_out_valid", longint'(out_valid), 0);
      tick; n++;
    end
    chk("clear_len", n, 41);
    chk("idle_busy", longint'(busy), 0);

    // Impulse response table
    for (int i = 0; i < 42; i++) begin
      tbl[i].din = (i == 0) ? 16'sd1 : 16'sd0;
      tbl[i].exp = (i < 41) ? longint'(COEF_H[(i <= 20) ? i : 40 - i]) : 64'sd0;
    end
    for (int i = 0; i < 42; i++) do_sample(tbl[i].din, 0, '0, "impulse", tbl[i].exp, 1'b1);

    // Full-scale DC settles to 32767 * 17583
    for (int i = 0; i < 45; i++)
      do_sample(16'sd32767, 0, '0, (i >= 40) ? "dc_settle" : "dc", 64'sd576142161, (i >= 40));

    // Random samples with short stalls and one long HOLD stall
    for (int i = 0; i < 21; i++) rd[i] = DATA_W'($urandom);
    for (int i = 0; i < 20; i++)
      do_sample(rd[i], (i == 5) ? 10 : int'($urandom_range(0, 2)), rd[i+1], "rand", 0, 1'b0);
    in_valid = 1'b0;

    // Back-to-back offers: one accept per NUM_TAPS+2 clocks, buffer pointer wraps
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DATA_W'($urandom);
    begin
      int acc_cnt, last_acc, cyc, outs;
      bit took;
      acc_cnt = 0; last_acc = -1; cyc = 0; outs = 0;
      while (outs < 50 && cyc < 5000) begin
        took = 1'b0;
        if (in_ready && in_valid) begin
          expq.push_back(model_push(in_data));
          if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 43);
          last_acc = cyc;
          acc_cnt++;
          took = 1'b1;
        end
        if (out_valid) begin
          if (expq.size() > 0) chk("b2b_data", out_data, expq.pop_front());
          else chk("b2b_extra_out", 1, 0);
          outs++;
        end
        tick; cyc++;
        if (took) begin
          in_data  = DATA_W'($urandom);
          in_valid = (acc_cnt < 50);
        end
      end
      chk("b2b_count", outs, 50);
    end
    in_valid = 1'b0;

`ifdef FIR_COEF_WR_EN
    // Load unit impulse into shadow bank, swap requested mid-RUN
    for (int t = 0; t < NUM_TAPS; t++) begin
      coef_we = 1'b1; coef_addr = 7'(t); coef_wdata = (t == 0) ? 12'sd1 : 12'sd0;
      tick;
    end
    coef_we = 1'b0;
    begin
      longint e;
      e = model_push(16'sd1234);
      in_valid = 1'b1; in_data = 16'sd1234;
      n = 0;
      while (!in_ready && n < 200) begin tick; n++; end
      tick;
      in_valid = 1'b0;
      repeat (10) tick;
      coef_swap = 1'b1;
      tick;
      coef_swap = 1'b0;
      n = 0;
      while (!out_valid && n < 60) begin tick; n++; end
      chk("swap_old_bank", out_data, e);
      tick;
    end
    use_unit = 1'b1;
    do_sample(-16'sd4321, 0, '0, "swap_new_bank", -64'sd4321, 1'b1);
`endif

    // Reset mid-RUN discards the sample and restarts CLEAR
    in_valid = 1'b1; in_data = 16'sd777;
    n = 0;
    while (!in_ready && n < 200) begin tick; n++; end
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_busy", longint'(busy), 1);
    chk("midrst_out_data", out_data, 0);
    hist.delete();
    use_unit = 1'b0;
    tick;
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    chk("midrst_clear_len", n, 41);
    do_sample(16'sd1000, 0, '0, "post_rst", 64'sd19000, 1'b1);
    do_sample(-16'sd500, 0, '0, "post_rst2", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
